regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//  Write-side front end of the 32-entry integer register file. It merges two result
//  producers into the register file's single write port:
//   - the single-cycle ALU
//   - the load/store unit (LSU), buffered in a small FIFO
//  Outputs are registered and drive the register file's write enable, write number
//  and write value directly.
// PARAMETERS
//  XLEN       32  data width of result values
//  REG_BITS   5   register-number width (2**REG_BITS registers)
//  LSU_DEPTH  4   LSU result FIFO depth (>=2, power of two)
// PORTS
//  clk              in   1          clock, rising edge
//  rst_n            in   1          asynchronous active-low reset
//  alu_valid        in   1          ALU result present
//  alu_ready        out  1          ALU result accepted this cycle when alu_valid=1
//  alu_rd           in   REG_BITS   ALU destination register
//  alu_value        in   XLEN       ALU result
//  lsu_valid        in   1          LSU load result present
//  lsu_ready        out  1          LSU result accepted this cycle when lsu_valid=1
//  lsu_rd           in   REG_BITS   LSU destination register
//  lsu_value        in   XLEN       LSU load data
//  wb_write_enable  out  1          register file write enable (registered)
//  wb_write_number  out  REG_BITS   register file write index (registered)
//  wb_write_value   out  XLEN       register file write data (registered)
//  lsu_count        out  clog2(LSU_DEPTH+1)  FIFO occupancy
//  busy             out  1          FIFO non-empty or write pending in output register
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, lsu_count=0.
//   wb_write_enable=0, wb_write_number=0, wb_write_value=0, busy=0.
//  Handshake: transfer on valid&&ready at a rising edge; producers hold payload while valid&&!ready.
//   - alu_ready = (lsu_count != LSU_DEPTH).
//   - lsu_ready = (lsu_count != LSU_DEPTH).
//   - Neither ready depends on any valid.
//  Per-cycle selection of the entry loaded into the output register, in priority order:
//   1. FIFO full: pop FIFO head; ALU stalled (alu_ready=0).
//   2. else alu_valid: take ALU. A simultaneous lsu_valid is pushed into the FIFO.
//   3. else FIFO non-empty: pop head. A simultaneous lsu_valid is pushed (push+pop, count unchanged).
//   4. else lsu_valid: bypass FIFO, take LSU directly.
//   5. else: nothing; wb_write_enable=0 next cycle.
//  Latency: result accepted at edge N appears on wb_* during cycle N+1 (one cycle).
//   FIFO-queued results drain in arrival order.
//  rd==0: accepted normally but suppressed; wb_write_enable stays 0.
//   wb_write_number/value still update to the selected entry.
//  wb_write_enable is a single-cycle pulse per selected non-x0 entry.
//   Back-to-back writes are allowed every cycle.
//  FIFO: circular buffer; read/write pointers wrap modulo LSU_DEPTH.
//   lsu_count = pushes - pops, never exceeds LSU_DEPTH.
//   A push when full is impossible (lsu_ready=0).
//  Ordering: no RAW ordering between ALU and LSU for the same rd is enforced here.
//   The issue stage guarantees no two in-flight results target the same rd.
//  busy = (lsu_count!=0) || wb_write_enable.
//  Reset mid-operation: queued LSU results are discarded, and any pending write is dropped
//   immediately (wb_write_enable falls asynchronously).
// TESTING
//  T1 reset: assert rst_n=0 mid-traffic
//     -> all wb_* outputs 0, lsu_count=0, busy=0, alu_ready=lsu_ready=1 without a clock edge.
//  T2 ALU alu_rd=5, alu_value=32'hDEADBEEF at edge N
//     -> cycle N+1: wb_write_enable=1, wb_write_number=5, wb_write_value=32'hDEADBEEF; cycle N+2: we=0.
//  T3 ALU alu_rd=0, alu_value=32'h1234
//     -> alu_ready=1, wb_write_enable stays 0 for all following cycles.
//  T4 ALU(rd=3,val=1) and LSU(rd=7,val=2) in the same cycle N
//     -> N+1 writes r3=1; N+2 writes r7=2; lsu_count goes 1 then 0.
//  T5 ALU valid every cycle plus LSU rd=10..13 on 4 consecutive cycles
//     -> lsu_count reaches 4; alu_ready=lsu_ready=0; r10,r11,r12,r13 written in order; ALU resumes.
//  T6 lsu_count=3, then rst_n pulsed low for 1 cycle
//     -> FIFO contents never written, lsu_count=0, next ALU result written with 1-cycle latency.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and FIFO-buffered LSU results into the register file write port; one-cycle
// registered latency. Both readies drop only while the LSU FIFO is full (FIFO drains first).

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_vld,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head_dat = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_vld)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end
endmodule

module regfile_writeback_arbiter #(
  parameter int XLEN      = 32,
  parameter int REG_BITS  = 5,
  parameter int LSU_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [REG_BITS-1:0]            alu_rd,
  input  logic [XLEN-1:0]                alu_value,
  input  logic                           lsu_valid,
  output logic                           lsu_ready,
  input  logic [REG_BITS-1:0]            lsu_rd,
  input  logic [XLEN-1:0]                lsu_value,
  output logic                           wb_write_enable,
  output logic [REG_BITS-1:0]            wb_write_number,
  output logic [XLEN-1:0]                wb_write_value,
  output logic [$clog2(LSU_DEPTH+1)-1:0] lsu_count,
  output logic                           busy
);
  localparam int CW = $clog2(LSU_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LSU_DEPTH);

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [XLEN-1:0]     value;
  } wb_entry_t;

  wb_entry_t alu_ent;
  wb_entry_t lsu_ent;
  wb_entry_t fifo_head;
  wb_entry_t sel_ent;
  logic      full;
  logic      empty;
  logic      sel_vld;
  logic      push;
  logic      pop;

  assign alu_ent   = '{rd: alu_rd, value: alu_value};
  assign lsu_ent   = '{rd: lsu_rd, value: lsu_value};
  assign full      = (lsu_count == FULL_CNT);
  assign empty     = (lsu_count == '0);
  assign alu_ready = !full;
  assign lsu_ready = !full;

  // A full FIFO wins over the ALU so LSU backpressure can never deadlock.
  always_comb begin
    sel_vld = 1'b0;
    sel_ent = fifo_head;
    push    = 1'b0;
    pop     = 1'b0;
    if (full) begin
      sel_vld = 1'b1;
      pop     = 1'b1;
    end else if (alu_valid) begin
      sel_vld = 1'b1;
      sel_ent = alu_ent;
      push    = lsu_valid;
    end else if (!empty) begin
      sel_vld = 1'b1;
      pop     = 1'b1;
      push    = lsu_valid;
    end else if (lsu_valid) begin
      sel_vld = 1'b1;
      sel_ent = lsu_ent;
    end
  end

  fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (LSU_DEPTH)
  ) u_lsu_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push),
    .push_dat (lsu_ent),
    .pop_vld  (pop),
    .head_dat (fifo_head),
    .count    (lsu_count)
  );

  // x0 results still move number/value but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_write_enable <= 1'b0;
      wb_write_number <= '0;
      wb_write_value  <= '0;
    end else begin
      wb_write_enable <= sel_vld && (sel_ent.rd != '0);
      if (sel_vld) begin
        wb_write_number <= sel_ent.rd;
        wb_write_value  <= sel_ent.value;
      end
    end
  end

  assign busy = (lsu_count != '0) || wb_write_enable;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed vector table, reset corner cases,
// then constrained-random traffic against a queue-based reference model.
module tb_regfile_writeback_arbiter;
  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_value;
  logic        wb_write_enable;
  logic [4:0]  wb_write_number;
  logic [31:0] wb_write_value;
  logic [2:0]  lsu_count;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_writeback_arbiter #(.XLEN(32), .REG_BITS(5), .LSU_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_value       (alu_value),
    .lsu_valid       (lsu_valid),
    .lsu_ready       (lsu_ready),
    .lsu_rd          (lsu_rd),
    .lsu_value       (lsu_value),
    .wb_write_enable (wb_write_enable),
    .wb_write_number (wb_write_number),
    .wb_write_value  (wb_write_value),
    .lsu_count       (lsu_count),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] aval;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lval;
    logic        rdy;
    logic        we;
    logic [4:0]  num;
    logic [31:0] val;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  logic        m_we;
  logic [4:0]  m_num;
  logic [31:0] m_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] num,
                         input logic [31:0] val, input logic [2:0] cnt);
    chk({tag, ".we"},    32'(wb_write_enable), 32'(we));
    chk({tag, ".num"},   32'(wb_write_number), 32'(num));
    chk({tag, ".val"},   wb_write_value, val);
    chk({tag, ".cnt"},   32'(lsu_count), 32'(cnt));
    chk({tag, ".busy"},  32'(busy), 32'((cnt != 3'd0) || we));
  endtask

  task automatic chk_rdy(input string tag, input logic rdy);
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(rdy));
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(rdy));
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lval);
    alu_valid = av; alu_rd = ard; alu_value = aval;
    lsu_valid = lv; lsu_rd = lrd; lsu_value = lval;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] lval,
                     input logic rdy, input logic we, input logic [4:0] num,
                     input logic [31:0] val, input logic [2:0] cnt);
    vec_t v;
    v.av = av; v.ard = ard; v.aval = aval; v.lv = lv; v.lrd = lrd; v.lval = lval;
    v.rdy = rdy; v.we = we; v.num = num; v.val = val; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Reference: the priority rules applied to an ordered queue of waiting LSU results.
  task automatic model_step(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] lval);
    ent_t e;
    bit   ld;
    ld = 0;
    e  = '0;
    if (mq.size() == 4) begin
      e = mq.pop_front(); ld = 1;
    end else if (av) begin
      e = '{ard, aval}; ld = 1;
      if (lv) mq.push_back('{lrd, lval});
    end else if (mq.size() != 0) begin
      e = mq.pop_front(); ld = 1;
      if (lv) mq.push_back('{lrd, lval});
    end else if (lv) begin
      e = '{lrd, lval}; ld = 1;
    end
    m_we = ld && (e.rd != 5'd0);
    if (ld) begin
      m_num = e.rd;
      m_val = e.val;
    end
  endtask

  initial begin
    logic        av, lv, rdy, hold;
    logic [4:0]  ard, lrd;
    logic [31:0] aval, lval;
    int          pa;

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    chk_out("reset", 1'b0, 5'd0, 32'd0, 3'd0);
    chk_rdy("reset", 1'b1);
    tick();
    tick();
    rst_n = 1'b1;

    //   av    ard    aval           lv    lrd     lval          rdy   we    num     val            cnt
    add(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 3'd0);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 3'd0);
    add(1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 5'd0,  32'h1234,     3'd0);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 5'd0,  32'h1234,     3'd0);
    add(1'b1, 5'd3,  32'd1,        1'b1, 5'd7,  32'd2,        1'b1, 1'b1, 5'd3,  32'd1,        3'd1);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 5'd7,  32'd2,        3'd0);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 5'd7,  32'd2,        3'd0);
    add(1'b1, 5'd20, 32'd100,      1'b1, 5'd10, 32'hA0,       1'b1, 1'b1, 5'd20, 32'd100,      3'd1);
    add(1'b1, 5'd21, 32'd101,      1'b1, 5'd11, 32'hA1,       1'b1, 1'b1, 5'd21, 32'd101,      3'd2);
    add(1'b1, 5'd22, 32'd102,      1'b1, 5'd12, 32'hA2,       1'b1, 1'b1, 5'd22, 32'd102,      3'd3);
    add(1'b1, 5'd23, 32'd103,      1'b1, 5'd13, 32'hA3,       1'b1, 1'b1, 5'd23, 32'd103,      3'd4);
    add(1'b1, 5'd24, 32'd104,      1'b0, 5'd0,  32'd0,        1'b0, 1'b1, 5'd10, 32'hA0,       3'd3);
    add(1'b1, 5'd24, 32'd104,      1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 5'd24, 32'd104,      3'd3);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 5'd11, 32'hA1,       3'd2);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 5'd12, 32'hA2,       3'd1);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 5'd13, 32'hA3,       3'd0);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b0, 5'd13, 32'hA3,       3'd0);
    add(1'b0, 5'd0,  32'd0,        1'b1, 5'd9,  32'd55,       1'b1, 1'b1, 5'd9,  32'd55,       3'd0);
    add(1'b1, 5'd1,  32'd1,        1'b1, 5'd2,  32'd2,        1'b1, 1'b1, 5'd1,  32'd1,        3'd1);
    add(1'b0, 5'd0,  32'd0,        1'b1, 5'd4,  32'd4,        1'b1, 1'b1, 5'd2,  32'd2,        3'd1);
    add(1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b1, 1'b1, 5'd4,  32'd4,        3'd0);
    add(1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  32'd77,       1'b1, 1'b0, 5'd0,  32'd77,       3'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].aval, tbl[i].lv, tbl[i].lrd, tbl[i].lval);
      #1;
      chk_rdy($sformatf("vec%0d", i), tbl[i].rdy);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].num, tbl[i].val, tbl[i].cnt);
    end

    // Asynchronous reset in the middle of traffic, no clock edge involved.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    tick();
    chk_out("t1_pre", 1'b1, 5'd3, 32'h33, 3'd2);
    rst_n = 1'b0;
    #2;
    chk_out("t1_async", 1'b0, 5'd0, 32'd0, 3'd0);
    chk_rdy("t1_async", 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // Three queued LSU results, then a one-cycle reset pulse discards them.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(15 + k), 32'(k), 1'b1, 5'(25 + k), 32'(32'hC0 + k));
      tick();
    end
    chk_out("t6_pre", 1'b1, 5'd17, 32'd2, 3'd3);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("t6_rst", 1'b0, 5'd0, 32'd0, 3'd0);
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    tick();
    chk_out("t6_alu", 1'b1, 5'd6, 32'h66, 3'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("t6_idle%0d", k), 1'b0, 5'd6, 32'h66, 3'd0);
    end

    // Random traffic against the reference model, starting from a fresh reset.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    mq.delete();
    m_we = 1'b0; m_num = 5'd0; m_val = 32'd0;
    hold = 1'b0;
    av = 1'b0; lv = 1'b0; ard = 5'd0; lrd = 5'd0; aval = 32'd0; lval = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      pa = ((c / 300) % 2 == 1) ? 90 : 35;
      if (!hold) begin
        av   = ($urandom_range(0, 99) < pa);
        ard  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        aval = $urandom;
        lv   = ($urandom_range(0, 99) < 55);
        lrd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        lval = $urandom;
      end
      drive(av, ard, aval, lv, lrd, lval);
      #1;
      rdy = (mq.size() != 4);
      chk_rdy($sformatf("rnd%0d", c), rdy);
      model_step(av, ard, aval, lv, lrd, lval);
      tick();
      chk_out($sformatf("rnd%0d", c), m_we, m_num, m_val, 3'(mq.size()));
      hold = (av || lv) && !rdy;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
